// File: rtl/output_controller.sv
// Ring output controller: arbitrates cw/pe input controllers into even/odd VC buffers.
// Optional OUTPUT_CONTROLLER_PKT_COUNT_EN adds a 16-bit sent_count port.
module output_controller #(
    parameter int DATA_WIDTH = 64,
    parameter int HOP_MSB    = 55
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  req_1,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic                  req_2,
    input  logic [DATA_WIDTH-1:0] data_2,
    output logic                  grant_1,
    output logic                  grant_2,
    output logic                  so,
    input  logic                  ro,
    output logic [DATA_WIDTH-1:0] dout
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
    ,
    output logic [15:0]           sent_count
`endif
);

    localparam int VC_BIT = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] even_buf;
    logic [DATA_WIDTH-1:0] odd_buf;
    logic                  even_full;
    logic                  odd_full;
    logic                  rr_ptr;

    logic                  w_full;
    logic                  l_full;
    logic [DATA_WIDTH-1:0] l_buf;
    logic                  elig_1;
    logic                  elig_2;
    logic                  both_elig;
    logic [DATA_WIDTH-1:0] cap_pkt;

    // Thermometer hop count: one hop consumed is a right shift by one.
    function automatic logic [DATA_WIDTH-1:0] dec_hop(
        input logic [DATA_WIDTH-1:0] pkt
    );
        logic [DATA_WIDTH-1:0] r;
        r = pkt;
        r[HOP_MSB -: 8] = {1'b0, pkt[HOP_MSB -: 7]};
        return r;
    endfunction

    // polarity=1: odd is writable, even on the link; polarity=0: the reverse.
    always_comb begin
        w_full = polarity ? odd_full : even_full;
        l_full = polarity ? even_full : odd_full;
        l_buf  = polarity ? even_buf : odd_buf;
    end

    always_comb begin
        elig_1    = req_1 & (data_1[VC_BIT] == polarity) & ~w_full & ~reset;
        elig_2    = req_2 & (data_2[VC_BIT] == polarity) & ~w_full & ~reset;
        both_elig = elig_1 & elig_2;
    end

    always_comb begin
        grant_1 = 1'b0;
        grant_2 = 1'b0;
        priority case (1'b1)
            both_elig: begin
                grant_1 = ~rr_ptr;
                grant_2 = rr_ptr;
            end
            elig_1:  grant_1 = 1'b1;
            elig_2:  grant_2 = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cap_pkt = dec_hop(grant_2 ? data_2 : data_1);
        so      = l_full & ro & ~reset;
        dout    = so ? l_buf : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            even_buf  <= '0;
            odd_buf   <= '0;
            even_full <= 1'b0;
            odd_full  <= 1'b0;
            rr_ptr    <= 1'b0;
        end else begin
            if (grant_1 | grant_2) begin
                if (polarity) begin
                    odd_buf  <= cap_pkt;
                    odd_full <= 1'b1;
                end else begin
                    even_buf  <= cap_pkt;
                    even_full <= 1'b1;
                end
            end
            // W and L are always different buffers, so these never collide.
            if (so) begin
                if (polarity) begin
                    even_full <= 1'b0;
                end else begin
                    odd_full <= 1'b0;
                end
            end
            if (both_elig) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sent_count <= '0;
        end else if (so) begin
            sent_count <= sent_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_output_controller.sv
// Randomized bench for output_controller against a buffer/queue-level model.
// Define OUTPUT_CONTROLLER_PKT_COUNT_EN to also check sent_count.
module tb_output_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        req_1;
    logic [63:0] data_1;
    logic        req_2;
    logic [63:0] data_2;
    logic        grant_1;
    logic        grant_2;
    logic        so;
    logic        ro;
    logic [63:0] dout;
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
    logic [15:0] sent_count;
`endif

    output_controller dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .req_1    (req_1),
        .data_1   (data_1),
        .req_2    (req_2),
        .data_2   (data_2),
        .grant_1  (grant_1),
        .grant_2  (grant_2),
        .so       (so),
        .ro       (ro),
        .dout     (dout)
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
        ,
        .sent_count (sent_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: two VC slots indexed by vc bit, fairness flag, send counter.
    logic [63:0] m_buf [2];
    bit          m_full [2];
    bit          m_rr;
    int          m_cnt;
    int          p_grant;
    bit          p_both;
    bit          p_so;
    bit          p_rst;
    bit          p_w;
    logic [63:0] p_pkt;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hop_step(input logic [63:0] d);
        logic [63:0] r;
        r = d;
        r[55:48] = d[55:48] / 2;
        return r;
    endfunction

    task automatic drive(input bit rst, input bit pol, input bit r1,
                         input logic [63:0] d1, input bit r2,
                         input logic [63:0] d2, input bit ro_v);
        bit e1, e2;
        int w, l;
        logic [63:0] exp_dout;
        @(negedge clk);
        reset    = rst;
        polarity = pol;
        req_1    = r1;
        data_1   = d1;
        req_2    = r2;
        data_2   = d2;
        ro       = ro_v;
        #2;
        w  = pol ? 1 : 0;
        l  = 1 - w;
        e1 = !rst && r1 && (d1[63] == pol) && !m_full[w];
        e2 = !rst && r2 && (d2[63] == pol) && !m_full[w];
        if (e1 && e2)  p_grant = m_rr ? 2 : 1;
        else if (e1)   p_grant = 1;
        else if (e2)   p_grant = 2;
        else           p_grant = 0;
        p_both   = e1 && e2;
        p_so     = !rst && m_full[l] && ro_v;
        p_rst    = rst;
        p_w      = pol;
        p_pkt    = (p_grant == 2) ? hop_step(d2) : hop_step(d1);
        exp_dout = p_so ? m_buf[l] : 64'h0;
        check("grant_1", {63'h0, grant_1}, {63'h0, p_grant == 1});
        check("grant_2", {63'h0, grant_2}, {63'h0, p_grant == 2});
        check("so", {63'h0, so}, {63'h0, p_so});
        check("dout", dout, exp_dout);
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
        check("sent_count", {48'h0, sent_count}, 64'(m_cnt & 16'hFFFF));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (p_rst) begin
            m_buf[0]  = '0;
            m_buf[1]  = '0;
            m_full[0] = 0;
            m_full[1] = 0;
            m_rr      = 0;
            m_cnt     = 0;
        end else begin
            if (p_grant != 0) begin
                m_buf[p_w]  = p_pkt;
                m_full[p_w] = 1;
            end
            if (p_so) begin
                m_full[!p_w] = 0;
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (p_both) m_rr = !m_rr;
        end
    endtask

    task automatic step(input bit rst, input bit pol, input bit r1,
                        input logic [63:0] d1, input bit r2,
                        input logic [63:0] d2, input bit ro_v);
        drive(rst, pol, r1, d1, r2, d2, ro_v);
        tick();
    endtask

    function automatic logic [63:0] rnd_pkt(input bit vc);
        logic [63:0] p;
        p = {$urandom, $urandom};
        p[63] = vc;
        if ($urandom_range(0, 3) != 0) p[55:48] = 8'hFF >> $urandom_range(0, 8);
        return p;
    endfunction

    localparam logic [63:0] PA = 64'h3f0f_aaaa_bbbb_cccc;
    localparam logic [63:0] PB = 64'hC0FF_1111_2222_3333;
    localparam logic [63:0] P1 = 64'h0007_0000_0000_0001;
    localparam logic [63:0] Z  = 64'h0;

    initial begin
        reset = 1; polarity = 0; req_1 = 0; req_2 = 0;
        data_1 = '0; data_2 = '0; ro = 0;
        m_buf[0] = '0; m_buf[1] = '0; m_full[0] = 0; m_full[1] = 0;
        m_rr = 0; m_cnt = 0;

        // Reset with a live request
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, P1, 0, Z, 1);
            check("rst_g1", {63'h0, grant_1}, 64'h0);
            check("rst_dout", dout, 64'h0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, i[0], 0, Z, 0, Z, 1);
            check("idle_so", {63'h0, so}, 64'h0);
            tick();
        end

        // Single capture and send
        drive(0, 0, 1, P1, 0, Z, 1);
        check("cap_g1", {63'h0, grant_1}, 64'h1);
        tick();
        drive(0, 1, 0, Z, 0, Z, 1);
        check("cap_so", {63'h0, so}, 64'h1);
        check("cap_dout", dout, 64'h0003_0000_0000_0001);
        tick();

        // VC mismatch
        drive(0, 0, 0, Z, 1, PB, 1);
        check("vc_g2_no", {63'h0, grant_2}, 64'h0);
        tick();
        drive(0, 1, 0, Z, 1, PB, 1);
        check("vc_g2_yes", {63'h0, grant_2}, 64'h1);
        tick();
        drive(0, 0, 0, Z, 0, Z, 1);
        check("vc_dout", dout, 64'hC07F_1111_2222_3333);
        tick();

        // Round robin 1,2,1,2
        for (int i = 0; i < 4; i++) begin
            drive(0, i[0], 1, rnd_pkt(i[0]), 1, rnd_pkt(i[0]), 1);
            check("rr_g1", {63'h0, grant_1}, {63'h0, !i[0]});
            check("rr_g2", {63'h0, grant_2}, {63'h0, i[0]});
            tick();
        end
        step(0, 0, 0, Z, 1, rnd_pkt(0), 1);
        drive(0, 1, 1, rnd_pkt(1), 1, rnd_pkt(1), 1);
        check("rr_hold", {63'h0, grant_1}, 64'h1);
        tick();
        step(0, 0, 0, Z, 0, Z, 1);

        // Backpressure with both buffers full
        step(0, 0, 1, PA, 0, Z, 0);
        step(0, 1, 1, PB, 0, Z, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, i[0], 1, rnd_pkt(i[0]), 1, rnd_pkt(i[0]), 0);
            check("bp_none", {62'h0, grant_1, grant_2}, 64'h0);
            tick();
        end
        drive(0, 0, 0, Z, 0, Z, 1);
        check("bp_odd", dout, 64'hC07F_1111_2222_3333);
        tick();
        drive(0, 1, 0, Z, 0, Z, 1);
        check("bp_even", dout, 64'h3f07_aaaa_bbbb_cccc);
        tick();

        // Reset while L full and ready
        step(0, 0, 1, PA, 0, Z, 1);
        drive(1, 1, 0, Z, 0, Z, 1);
        check("mid_rst_so", {63'h0, so}, 64'h0);
        tick();
        drive(0, 1, 0, Z, 0, Z, 1);
        check("discard_so", {63'h0, so}, 64'h0);
        tick();
        step(0, 0, 1, PA, 0, Z, 1);
        step(0, 1, 1, PB, 0, Z, 1);
        step(0, 0, 1, PA, 0, Z, 1);
        step(0, 1, 0, Z, 0, Z, 1);
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
        drive(0, 0, 0, Z, 0, Z, 0);
        check("cnt3", {48'h0, sent_count}, 64'd3);
        tick();
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit pol;
            pol = $urandom_range(0, 1);
            step($urandom_range(0, 49) == 0, pol,
                 $urandom_range(0, 1), rnd_pkt($urandom_range(0, 3) != 0 ? pol : !pol),
                 $urandom_range(0, 1), rnd_pkt($urandom_range(0, 3) != 0 ? pol : !pol),
                 $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
